// File: rtl/operand_capture_pkg.sv
// Shared types, default parameters and index-width helper for the operand capture front end.
package operand_capture_pkg;

  typedef enum logic [1:0] {
    COLLECT,
    ARM,
    FIRE,
    WAIT_DONE
  } state_t;

  localparam int unsigned DEF_WIDTH           = 8;
  localparam int unsigned DEF_NUM_OPERANDS    = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;

  // Slot index width: max(1, clog2(n)).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Push-button debounce filter: the output level flips after DEBOUNCE_CYCLES consecutive disagreeing
// samples. Define OPERAND_CAPTURE_SYNC_EN to insert a two-flop synchroniser ahead of the filter.
module debounce_filter
  import operand_capture_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic sample;

`ifdef OPERAND_CAPTURE_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], din};
    end
  end

  assign sample = sync_q[1];
`else
  assign sample = din;
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;

  // Counter clears on any agreeing sample and on the toggle itself.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sample != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = ~db_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign dout = db_q;

endmodule

// File: rtl/operand_capture_unit.sv
// Operand entry front end: captures NUM_OPERANDS switch values, one per debounced press, then
// launches the multiplier and locks out input until mult_done. OPERAND_CAPTURE_SYNC_EN adds a sync.
module operand_capture_unit
  import operand_capture_pkg::*;
#(
  parameter int unsigned WIDTH           = DEF_WIDTH,
  parameter int unsigned NUM_OPERANDS    = DEF_NUM_OPERANDS,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             btn,
  input  logic [WIDTH-1:0]                 sw,
  input  logic                             mult_done,
  output logic [NUM_OPERANDS*WIDTH-1:0]    operands,
  output logic [idx_w(NUM_OPERANDS)-1:0]   op_index,
  output logic                             start,
  output logic                             busy
);

  localparam int unsigned IDX_W = idx_w(NUM_OPERANDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPERANDS - 1);

  logic btn_db, btn_db_q;
  logic press, rel, capture;

  state_t state_q, state_d;

  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [NUM_OPERANDS-1:0][WIDTH-1:0] ops_q, ops_d;

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .reset(reset),
    .din  (btn),
    .dout (btn_db)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_db_q <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
    end
  end

  assign press = btn_db & ~btn_db_q;
  assign rel   = ~btn_db & btn_db_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT:   if (press && (idx_q == LAST_IDX)) state_d = ARM;
      ARM:       if (rel) state_d = FIRE;
      FIRE:      state_d = WAIT_DONE;
      WAIT_DONE: if (mult_done) state_d = COLLECT;
      default:   state_d = COLLECT;
    endcase
  end

  always_comb begin
    start   = (state_q == FIRE);
    busy    = (state_q == WAIT_DONE);
    capture = (state_q == COLLECT) && press;
  end

  // The last slot keeps its index until mult_done rewinds to slot 0.
  always_comb begin
    ops_d = ops_q;
    idx_d = idx_q;
    if (capture) begin
      ops_d[idx_q] = sw;
      if (idx_q != LAST_IDX) begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else if (busy && mult_done) begin
      idx_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ops_q <= '0;
      idx_q <= '0;
    end else begin
      ops_q <= ops_d;
      idx_q <= idx_d;
    end
  end

  assign operands = ops_q;
  assign op_index = idx_q;

endmodule

// File: tb/tb_operand_capture_unit.sv
// Self-checking bench: two configurations run against a behavioural model every cycle,
// plus directed literal expectations at hand-computed cycles.
module tb_operand_capture_unit;

`ifdef OPERAND_CAPTURE_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  localparam logic [1:0] PH_COLLECT = 2'd0;
  localparam logic [1:0] PH_ARM     = 2'd1;
  localparam logic [1:0] PH_FIRE    = 2'd2;
  localparam logic [1:0] PH_WAIT    = 2'd3;

  typedef struct packed {
    logic        db;
    logic        dbp;
    logic [63:0] hist;
    logic [1:0]  phase;
    int unsigned idx;
    logic [63:0] ops;
  } model_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic        btn_a = 1'b0, done_a = 1'b0;
  logic [7:0]  sw_a = '0;
  logic [15:0] operands_a;
  logic [0:0]  op_index_a;
  logic        start_a, busy_a;

  logic        btn_b = 1'b0, done_b = 1'b0;
  logic [3:0]  sw_b = '0;
  logic [11:0] operands_b;
  logic [1:0]  op_index_b;
  logic        start_b, busy_b;

  int checks = 0;
  int errors = 0;

  model_t ma = '0;
  model_t mb = '0;

  always #5 clk = ~clk;

  operand_capture_unit #(
    .WIDTH(8), .NUM_OPERANDS(2), .DEBOUNCE_CYCLES(4)
  ) dut_a (
    .clk(clk), .reset(reset), .btn(btn_a), .sw(sw_a), .mult_done(done_a),
    .operands(operands_a), .op_index(op_index_a), .start(start_a), .busy(busy_a)
  );

  operand_capture_unit #(
    .WIDTH(4), .NUM_OPERANDS(3), .DEBOUNCE_CYCLES(1)
  ) dut_b (
    .clk(clk), .reset(reset), .btn(btn_b), .sw(sw_b), .mult_done(done_b),
    .operands(operands_b), .op_index(op_index_b), .start(start_b), .busy(busy_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Debounced level flips once the last d (delayed) raw samples all disagree with it.
  function automatic model_t step(input model_t m, input logic rst, input logic b,
                                  input logic [63:0] s, input logic done,
                                  input int w, input int n, input int d);
    model_t r;
    logic   pr, rl, flip;
    if (rst) return '0;
    r  = m;
    pr = m.db & ~m.dbp;
    rl = ~m.db & m.dbp;
    case (m.phase)
      PH_COLLECT: if (pr) begin
        for (int k = 0; k < w; k++) r.ops[int'(m.idx) * w + k] = s[k];
        if (int'(m.idx) == n - 1) r.phase = PH_ARM;
        else r.idx = m.idx + 1;
      end
      PH_ARM:  if (rl) r.phase = PH_FIRE;
      PH_FIRE: r.phase = PH_WAIT;
      default: if (done) begin
        r.idx   = 0;
        r.phase = PH_COLLECT;
      end
    endcase
    r.dbp  = m.db;
    r.hist = {m.hist[62:0], b};
    flip   = 1'b1;
    for (int i = 0; i < d; i++) if (r.hist[SYNC_LAT + i] == r.db) flip = 1'b0;
    if (flip) r.db = ~r.db;
    return r;
  endfunction

  always @(posedge clk) begin
    ma <= step(ma, reset, btn_a, 64'(sw_a), done_a, 8, 2, 4);
    mb <= step(mb, reset, btn_b, 64'(sw_b), done_b, 4, 3, 1);
  end

  always @(negedge clk) begin
    check("a_operands", 64'(operands_a), ma.ops);
    check("a_op_index", 64'(op_index_a), 64'(ma.idx));
    check("a_start", 64'(start_a), 64'(ma.phase == PH_FIRE));
    check("a_busy", 64'(busy_a), 64'(ma.phase == PH_WAIT));
    check("b_operands", 64'(operands_b), mb.ops);
    check("b_op_index", 64'(op_index_b), 64'(mb.idx));
    check("b_start", 64'(start_b), 64'(mb.phase == PH_FIRE));
    check("b_busy", 64'(busy_b), 64'(mb.phase == PH_WAIT));
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic press_a(input logic [7:0] v);
    sw_a = v; btn_a = 1'b1; cyc(8);
    btn_a = 1'b0; cyc(8);
  endtask

  task automatic press_b(input logic [3:0] v);
    sw_b = v; btn_b = 1'b1; cyc(6);
    btn_b = 1'b0; cyc(6);
  endtask

  initial begin
    cyc(2);
    reset = 1'b0;
    check("reset_operands", 64'(operands_a), 64'h0);
    check("reset_index", 64'(op_index_a), 64'h0);

    // Three-cycle glitch never reaches the debounced level.
    sw_a = 8'h5A; btn_a = 1'b1; cyc(3);
    btn_a = 1'b0; cyc(10);
    check("glitch_operands", 64'(operands_a), 64'h0);
    check("glitch_index", 64'(op_index_a), 64'h0);

    // First operand lands exactly at e(D+1).
    sw_a = 8'h0C; btn_a = 1'b1; cyc(4 + SYNC_LAT);
    check("cap0_before", 64'(operands_a), 64'h0);
    cyc(1);
    check("cap0_at_e5", 64'(operands_a), 64'h000C);
    check("cap0_index", 64'(op_index_a), 64'h1);
    cyc(3);
    btn_a = 1'b0; cyc(8);

    // Second operand, then start exactly D+1 edges after release begins.
    sw_a = 8'hF3; btn_a = 1'b1; cyc(8);
    check("cap1_operands", 64'(operands_a), 64'hF30C);
    btn_a = 1'b0; cyc(4 + SYNC_LAT);
    check("start_early", 64'(start_a), 64'h0);
    cyc(1);
    check("start_pulse", 64'(start_a), 64'h1);
    check("busy_during_start", 64'(busy_a), 64'h0);
    cyc(1);
    check("start_single", 64'(start_a), 64'h0);
    check("busy_after_start", 64'(busy_a), 64'h1);

    // Lockout while busy.
    press_a(8'hFF);
    check("lockout_operands", 64'(operands_a), 64'hF30C);
    check("lockout_busy", 64'(busy_a), 64'h1);
    done_a = 1'b1; cyc(1);
    done_a = 1'b0;
    check("done_busy", 64'(busy_a), 64'h0);
    check("done_index", 64'(op_index_a), 64'h0);
    press_a(8'hAA);
    check("overwrite_slot0", 64'(operands_a), 64'hF3AA);
    check("overwrite_index", 64'(op_index_a), 64'h1);

    // Button held across mult_done causes no capture.
    press_a(8'h11);
    check("second_op_busy", 64'(busy_a), 64'h1);
    sw_a = 8'h77; btn_a = 1'b1; cyc(8);
    done_a = 1'b1; cyc(1);
    done_a = 1'b0; cyc(8);
    check("held_no_capture", 64'(operands_a), 64'h11AA);
    check("held_index", 64'(op_index_a), 64'h0);
    btn_a = 1'b0; cyc(8);
    press_a(8'h22);
    check("after_held", 64'(operands_a), 64'h1122);

    // Reset while in ARM.
    reset = 1'b1; cyc(1);
    reset = 1'b0;
    press_a(8'h0C);
    sw_a = 8'hF3; btn_a = 1'b1; cyc(8);
    check("arm_operands", 64'(operands_a), 64'hF30C);
    reset = 1'b1; btn_a = 1'b0; cyc(1);
    reset = 1'b0;
    check("rst_operands", 64'(operands_a), 64'h0);
    check("rst_index", 64'(op_index_a), 64'h0);
    check("rst_start", 64'(start_a), 64'h0);
    check("rst_busy", 64'(busy_a), 64'h0);
    cyc(20);

    // Button held through reset deassertion is captured after the normal delay.
    sw_a = 8'h5A; btn_a = 1'b1; reset = 1'b1; cyc(2);
    reset = 1'b0; cyc(4 + SYNC_LAT);
    check("held_rst_before", 64'(operands_a), 64'h0);
    cyc(1);
    check("held_rst_capture", 64'(operands_a), 64'h005A);
    btn_a = 1'b0; cyc(8);

    // Second configuration: three 4-bit operands, single-sample debounce.
    press_b(4'h3);
    check("b_idx1", 64'(op_index_b), 64'h1);
    press_b(4'h7);
    check("b_idx2", 64'(op_index_b), 64'h2);
    press_b(4'h9);
    check("b_operands_973", 64'(operands_b), 64'h973);
    check("b_busy_lit", 64'(busy_b), 64'h1);
    done_b = 1'b1; cyc(1);
    done_b = 1'b0;
    check("b_idx_wrap", 64'(op_index_b), 64'h0);
    press_b(4'h5);
    check("b_slot0_only", 64'(operands_b), 64'h975);
    cyc(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_capture_unit.md
# operand_capture_unit

Parametrised operand-entry front end for the sequential multiplier. It debounces a single push button and captures `NUM_OPERANDS` values of `WIDTH` bits from the switch bank, one operand per press. After the last operand's button release it pulses `start`, then locks out input until the multiplier reports `mult_done`. It sits between the board I/O (button, switches) and the multiplier datapath/control.

## Interface
- `WIDTH`, 8: operand width in bits (≥1).
- `NUM_OPERANDS`, 2: operands captured per operation (≥2).
- `DEBOUNCE_CYCLES`, 4: consecutive identical samples needed to change the debounced level (≥1).
- `clk` in 1: system clock; one clock domain.
- `reset` in 1: reset is synchronous and active-high.
- `btn` in 1: raw push button, active-high.
- `sw` in `WIDTH`: operand value presented by the switches.
- `mult_done` in 1: multiplier finished; single-cycle pulse or level.
- `operands` out `NUM_OPERANDS*WIDTH`: captured operands; operand i at bits `[i*WIDTH +: WIDTH]`.
- `op_index` out `IDX_W`: slot the next press writes; `IDX_W = max(1, $clog2(NUM_OPERANDS))`.
- `start` out 1: one-cycle launch pulse to the multiplier.
- `busy` out 1: high from `start` until `mult_done` is accepted.

## Operation
- Debounce: `btn_db` is registered. `cnt` counts consecutive edges where the sampled `btn` differs from `btn_db`. `cnt` clears when they match. When `cnt` reaches `DEBOUNCE_CYCLES`, `btn_db` toggles and `cnt` clears. Pulses shorter than `DEBOUNCE_CYCLES` cycles have no effect.
- Edge detect: `btn_db_q` is `btn_db` delayed one cycle. `press = btn_db & ~btn_db_q`. `release = ~btn_db & btn_db_q`.
- FSM states:
  - COLLECT: on `press`, write `sw` into slot `op_index`. If `op_index == NUM_OPERANDS-1`, go to ARM; otherwise increment `op_index`.
  - ARM: wait for `release`, then go to FIRE. Further presses are ignored.
  - FIRE: `start = 1` for exactly this cycle. Go to WAIT_DONE.
  - WAIT_DONE: `busy = 1`. Presses are ignored and `operands` hold. When `mult_done = 1`, clear `op_index` to 0 and go to COLLECT.
- `mult_done` is sampled only in WAIT_DONE; in every other state it is ignored.
- `operands` are written only in COLLECT on `press`; they otherwise hold, including across operations until overwritten.
- A button still held when returning to COLLECT causes no capture, because there is no new `press`.
- `sw` is sampled on the capture edge only; changes at any other time are ignored.
- Reset (any state, any cycle):
  - `operands = 0`, `op_index = 0`, `start = 0`, `busy = 0`.
  - `btn_db = 0`, `btn_db_q = 0`, `cnt = 0`, state COLLECT.
  - A button held through reset deassertion is captured after the normal debounce delay.

## Timing
- Edge e1 is the first of `DEBOUNCE_CYCLES` consecutive edges sampling `btn = 1`. Let D = `DEBOUNCE_CYCLES`.
- Press timing:
  - `btn_db` rises at edge eD.
  - `press` is high in the cycle after eD.
  - The slot and `op_index` update at edge eD+1.
- Release timing, same counting:
  - `btn_db` falls at rD.
  - `release` is high after rD; state becomes FIRE at rD+1.
  - `start` is high between rD+1 and rD+2.
  - `busy` rises at rD+2.
- `mult_done` sampled at edge k in WAIT_DONE: `busy = 0` and `op_index = 0` after k, and a new press is accepted from k+1.
- Throughput: one operation per full collect/launch/done cycle. No overlap.

## Configuration
- `OPERAND_CAPTURE_SYNC_EN` defined: a two-flop synchroniser precedes the debounce filter, adding 2 cycles to every press and release latency above.
- `OPERAND_CAPTURE_SYNC_EN` undefined: `btn` feeds the debounce filter directly.
- All other behaviour is identical in both builds.

## Structure
- Package `operand_capture_pkg` holds:
  - the `state_t` enum {COLLECT, ARM, FIRE, WAIT_DONE};
  - default-parameter constants (`DEF_WIDTH`, `DEF_NUM_OPERANDS`, `DEF_DEBOUNCE_CYCLES`);
  - the `IDX_W` computation function.
- Sub-module `debounce_filter`, parameter `DEBOUNCE_CYCLES`, contains the counter, `btn_db` and the optional synchroniser. Ports: `clk`, `reset`, `din`, `dout`.
- Edge detect, FSM and operand register array live in `operand_capture_unit`.

## Test plan
- **Debounce reject:** `WIDTH=8`, `NUM_OPERANDS=2`, `DEBOUNCE_CYCLES=4`. Three-cycle `btn` glitch with `sw=8'h5A` -> `operands` stay 0 and `op_index` stays 0.
- **Two-operand capture:**
  - `sw=8'h0C`, then hold `btn` 10 cycles and release -> `operands[7:0]=8'h0C` at edge e5, `op_index=1`.
  - `sw=8'hF3`, then press and release -> `operands[15:8]=8'hF3`.
  - `start` is a single pulse exactly 5 edges after release begins; `busy=1` afterwards.
- **Lockout:** presses with `sw=8'hFF` while `busy=1` -> `operands` unchanged. `mult_done` pulse -> `busy=0` and `op_index=0` next cycle; the next press overwrites slot 0 only.
- **Held across done:** button held while `mult_done` arrives -> no capture until release plus a new press.
- **Reset mid-operation:** `reset=1` for 1 cycle in ARM with `operands=16'hF30C` -> all outputs 0 and no `start` afterwards.
- **Generalisation:** `WIDTH=4`, `NUM_OPERANDS=3`, `DEBOUNCE_CYCLES=1`, in both builds (with and without `OPERAND_CAPTURE_SYNC_EN`). Captures 3/7/9 -> `operands=12'h973`, and `op_index` wraps 0→1→2→0 after `mult_done`.
